// File: rtl/kernel_sysid_checker.sv
// rtl/kernel_sysid_checker.sv - reads the sysid ID and timestamp words over Avalon and checks them
//
// Purpose: on a start pulse, read the ID word (address 0) and the build
// timestamp word (address 1) from a sysid slave, compare them against the
// expected values and report the result. A per-read stall limit aborts the
// sequence if the slave holds waitrequest too long.
//
// Ports:
//   clock              rising-edge system clock
//   reset              synchronous, active-high reset
//   start              one-cycle request to run a check (ignored while busy)
//   sysid_address      Avalon address (0 = ID word, 1 = timestamp word)
//   sysid_read         Avalon read strobe
//   sysid_waitrequest  slave stall
//   sysid_readdata     slave read data
//   busy               sequence in progress
//   done               one-cycle pulse at the end of each sequence
//   id_ok / ts_ok      captured words match the expected values
//   timeout            sequence aborted on the stall limit
//   id_value / ts_value last captured words
module kernel_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0FFF_FFFF,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h5B7E_C4CA,
  parameter int          TIMEOUT            = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic        sysid_waitrequest,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD_ID = 2'd1,
    S_RD_TS = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // The stall that would bring the counter up to TIMEOUT is the last one
  // allowed; comparing against TIMEOUT-1 lets the abort happen on that cycle.
  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] stall_q, stall_d;
  logic        address_q, address_d;
  logic        read_q, read_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  always_comb begin
    state_d    = state_q;
    stall_d    = stall_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RD_ID;
          stall_d    = 16'd0;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          timeout_d  = 1'b0;
          id_value_d = 32'd0;
          ts_value_d = 32'd0;
        end
      end

      S_RD_ID: begin
        // A completing read wins over the stall limit in the same cycle.
        if (!sysid_waitrequest) begin
          id_value_d = sysid_readdata;
          state_d    = S_RD_TS;
          stall_d    = 16'd0;
        end else begin
          stall_d = stall_q + 16'd1;
          if (stall_q == STALL_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
          end
        end
      end

      S_RD_TS: begin
        if (!sysid_waitrequest) begin
          ts_value_d = sysid_readdata;
          state_d    = S_DONE;
          // Flags are resolved on entry to DONE so they are valid with the
          // done pulse; the timestamp is compared straight off the bus.
          id_ok_d    = (id_value_q == EXPECTED_ID);
          ts_ok_d    = (sysid_readdata == EXPECTED_TIMESTAMP);
        end else begin
          stall_d = stall_q + 16'd1;
          if (stall_q == STALL_LAST) begin
            state_d   = S_DONE;
            timeout_d = 1'b1;
            id_ok_d   = 1'b0;
            ts_ok_d   = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Bus and status outputs are registered copies decoded from the next state.
    read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
    address_d = (state_d == S_RD_TS);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      stall_q    <= 16'd0;
      address_q  <= 1'b0;
      read_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      stall_q    <= stall_d;
      address_q  <= address_d;
      read_q     <= read_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign sysid_address = address_q;
  assign sysid_read    = read_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign id_ok         = id_ok_q;
  assign ts_ok         = ts_ok_q;
  assign timeout       = timeout_q;
  assign id_value      = id_value_q;
  assign ts_value      = ts_value_q;

endmodule

// File: doc/kernel_sysid_checker.md
KERNEL_SYSID_CHECKER -- requirements
Module: kernel_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0FFF_FFFF, the system ID value the checker requires.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'h5B7E_C4CA, the build timestamp the checker requires.
REQ-003 Parameter TIMEOUT, default 255, the maximum number of stalled cycles allowed per read (range 1..65535).
REQ-004 Port clock  input  1  single system clock; all logic is on its rising edge.
REQ-005 Port reset  input  1  reset; synchronous and active-high.
REQ-006 Port start  input  1  one-cycle request to run a check sequence.
REQ-007 Port sysid_address  output  1  Avalon master address to the sysid slave (0 = ID word, 1 = timestamp word).
REQ-008 Port sysid_read  output  1  Avalon master read strobe.
REQ-009 Port sysid_waitrequest  input  1  slave stall; tie low for a zero-wait-state slave.
REQ-010 Port sysid_readdata  input  32  slave read data, valid in any cycle with sysid_read=1 and sysid_waitrequest=0.
REQ-011 Port busy  output  1  high while a sequence is in progress.
REQ-012 Port done  output  1  one-cycle pulse at the end of each sequence.
REQ-013 Port id_ok  output  1  captured ID equals EXPECTED_ID.
REQ-014 Port ts_ok  output  1  captured timestamp equals EXPECTED_TIMESTAMP.
REQ-015 Port timeout  output  1  the sequence aborted on a stall limit.
REQ-016 Port id_value  output  32  last captured ID word.
REQ-017 Port ts_value  output  32  last captured timestamp word.

Function
REQ-018 The FSM SHALL have states IDLE, RD_ID, RD_TS and DONE, with all outputs registered.
REQ-019 In IDLE, start=1 SHALL move the FSM to RD_ID on the next edge and SHALL clear id_ok, ts_ok, timeout, id_value and ts_value on that same edge.
REQ-020 In RD_ID, outputs SHALL be sysid_read=1 and sysid_address=0; the first cycle with sysid_waitrequest=0 SHALL capture sysid_readdata into id_value and move the FSM to RD_TS.
REQ-021 In RD_TS, outputs SHALL be sysid_read=1 and sysid_address=1; the first cycle with sysid_waitrequest=0 SHALL capture sysid_readdata into ts_value and move the FSM to DONE.
REQ-022 Latency SHALL be fixed: with waitrequest always low, start in cycle N gives RD_ID in N+1, RD_TS in N+2, done=1 in N+3 and IDLE in N+4.
REQ-023 A 16-bit stall counter SHALL clear on entry to each read state and increment in every cycle with waitrequest=1.
REQ-024 When the stall counter reaches TIMEOUT with waitrequest still 1, the FSM SHALL go to DONE with timeout=1; the pending word is not captured.
REQ-025 In DONE, done=1 for exactly one cycle, id_ok and ts_ok SHALL be set from 32-bit equality compares (both forced 0 when timeout=1), and the FSM SHALL then return to IDLE.
REQ-026 id_ok, ts_ok, timeout, id_value and ts_value SHALL hold their values until the next accepted start or reset.
REQ-027 busy SHALL be 1 in RD_ID, RD_TS and DONE, and 0 in IDLE.
REQ-028 start SHALL be ignored outside IDLE; no sequence is queued.
REQ-029 sysid_read SHALL be 0 in IDLE and DONE, and sysid_address SHALL be 0 whenever sysid_read=0.
REQ-030 If waitrequest falls in the same cycle the counter reaches TIMEOUT, the capture SHALL take priority over the timeout.

Reset
REQ-031 reset=1 at a clock edge SHALL force IDLE, with every output and the stall counter at 0, including mid-sequence; no done pulse SHALL be produced for the aborted sequence.
REQ-032 reset SHALL take priority over start in the same cycle.

Verification
REQ-033 Zero-wait slave returning 0x0FFFFFFF at address 0 and 0x5B7EC4CA at address 1, start pulse in cycle N -> done in N+3 with id_ok=1, ts_ok=1, timeout=0 and values captured exactly.
REQ-034 Slave returning 0x12345678 at address 0, with otherwise matching defaults -> id_ok=0, ts_ok=1, id_value=0x12345678.
REQ-035 waitrequest held for 3 cycles in RD_ID, TIMEOUT=255 -> RD_ID lasts 4 cycles, done in N+6, both ok flags 1.
REQ-036 waitrequest stuck high, TIMEOUT=4 -> done after the 4th stalled cycle with timeout=1, id_ok=0, ts_ok=0, id_value=0.
REQ-037 start pulses repeated while busy, then reset asserted in RD_TS -> exactly one sequence runs until the reset, all outputs are 0 on the next cycle, and no done pulse appears.
REQ-038 Case of REQ-030: waitrequest falls on the cycle the counter reaches TIMEOUT -> the word is captured and timeout=0.
